// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: default word width,
// FSM state encoding and statistics counter width.
package dmem_ctrl_pkg;

    localparam int DATA_WID_DEF = 32;
    localparam int STAT_WID     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } dmem_state_e;

    // Index width that never collapses to zero bits for tiny sizes.
    function automatic int clog2_min1(input int val);
        return (val > 1) ? $clog2(val) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so it holds the last value read.
module dmem_array
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_WID = DATA_WID_DEF,
    parameter int DEPTH    = 1024,
    localparam int AW      = clog2_min1(DEPTH),
    localparam int NB      = DATA_WID / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_WID-1:0] wdata,
    input  logic [NB-1:0]       be,
    output logic [DATA_WID-1:0] rdata
);

    logic [DATA_WID-1:0] mem_q [DEPTH];
    logic [DATA_WID-1:0] rdata_q;
    logic [DATA_WID-1:0] rdata_d;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready/done handshake, configurable wait states
// and registered out-of-range error. Optional counters under DMEM_STATS_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_WID    = DATA_WID_DEF,
    parameter int ADDR_WID    = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    localparam int NB         = DATA_WID / 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req,
    input  logic                write_flag,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] write_data,
    input  logic [NB-1:0]       byte_en,
    output logic                ready,
    output logic                done,
    output logic [DATA_WID-1:0] valM,
    output logic                dmem_error
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_WID-1:0] rd_count,
    output logic [STAT_WID-1:0] wr_count,
    output logic [STAT_WID-1:0] err_count
`endif
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(WAIT_CYCLES + 1);

    dmem_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DATA_WID-1:0] wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic                err_q, err_d;
    logic                arr_we, arr_re;
    logic                in_range;

    // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_WID.
    assign in_range = ({1'b0, addr} < (ADDR_WID+1)'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        arr_we  = 1'b0;
        arr_re  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = AW'(addr);
                    wr_d    = write_flag;
                    wdata_d = write_data;
                    be_d    = byte_en;
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d = 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_d = ST_ACCESS;
                        end else begin
                            cnt_d   = CW'(WAIT_CYCLES - 1);
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                arr_we  = wr_q;
                arr_re  = !wr_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DATA_WID (DATA_WID),
        .DEPTH    (DEPTH)
    ) u_array (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .be    (be_q),
        .rdata (valM)
    );

    assign ready      = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign dmem_error = (state_q == ST_DONE) && err_q;

`ifdef DMEM_STATS_EN
    logic [STAT_WID-1:0] rd_cnt_q, rd_cnt_d;
    logic [STAT_WID-1:0] wr_cnt_q, wr_cnt_d;
    logic [STAT_WID-1:0] err_cnt_q, err_cnt_d;

    // Counts land on the edge that ends the done pulse; all saturate.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (done) begin
            if (err_q) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end else if (wr_q) begin
                if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (DEPTH=1024, 11-bit addr so addr=DEPTH is
// expressible). Table-driven transactions feed a scoreboard checked on done.
module tb_dmem_ctrl;

    localparam int DW  = 32;
    localparam int AWD = 11;
    localparam int DEP = 1024;
    localparam int WC  = 2;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           req = 1'b0;
    logic           write_flag = 1'b0;
    logic [AWD-1:0] addr = '0;
    logic [DW-1:0]  write_data = '0;
    logic [3:0]     byte_en = '0;
    logic           ready;
    logic           done;
    logic [DW-1:0]  valM;
    logic           dmem_error;
`ifdef DMEM_STATS_EN
    logic [15:0]    rd_count, wr_count, err_count;
`endif

    dmem_ctrl #(
        .DATA_WID    (DW),
        .ADDR_WID    (AWD),
        .DEPTH       (DEP),
        .WAIT_CYCLES (WC)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req        (req),
        .write_flag (write_flag),
        .addr       (addr),
        .write_data (write_data),
        .byte_en    (byte_en),
        .ready      (ready),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error)
`ifdef DMEM_STATS_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err_count  (err_count)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int err_leak = 0;

    typedef struct {
        bit          wr;
        int unsigned a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          exp_err;
        logic [31:0] exp_val;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] val;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no transaction (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn done: cycle=%0d err=%0b valM=%h", cyc, dmem_error, valM);
                    check("done_err", {31'b0, dmem_error}, {31'b0, e.err});
                    check("done_valM", valM, e.val);
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end else if (dmem_error) begin
                err_leak++;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (!ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready=0, expected 1 within 50 cycles");
        end
    endtask

    // Leaves the caller at the negedge right after the acceptance edge.
    task automatic drive(input bit wr, input int unsigned a, input logic [31:0] d,
                         input logic [3:0] be, input bit push, input bit exp_err,
                         input logic [31:0] exp_val);
        exp_t e;
        wait_ready();
        req        = 1'b1;
        write_flag = wr;
        addr       = AWD'(a);
        write_data = d;
        byte_en    = be;
        if (push) begin
            e.err = exp_err;
            e.val = exp_val;
            e.acc = cyc + 1;
            e.lat = exp_err ? 1 : 2 + WC;
            sb.push_back(e);
        end
        @(negedge CLK);
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[17];

    initial begin
        // wr, addr, data, be, exp_err, valM expected at done
        vecs[0]  = '{1'b1, 5,    32'hDEADBEEF, 4'hF,    1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 5,    32'h0,        4'h0,    1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 7,    32'h11223344, 4'hF,    1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 7,    32'hAABBCCDD, 4'b0101, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 7,    32'h0,        4'h0,    1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b0, 1024, 32'h0,        4'h0,    1'b1, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 1023, 32'hCAFEF00D, 4'hF,    1'b0, 32'h11BB33DD};
        vecs[7]  = '{1'b0, 1023, 32'h0,        4'h0,    1'b0, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 0,    32'hFFFFFFFF, 4'hF,    1'b0, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 0,    32'h01020304, 4'b1010, 1'b0, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 0,    32'h0,        4'h0,    1'b0, 32'h01FF03FF};
        vecs[11] = '{1'b1, 7,    32'h00000000, 4'h0,    1'b0, 32'h01FF03FF};
        vecs[12] = '{1'b0, 7,    32'h0,        4'h0,    1'b0, 32'h11BB33DD};
        vecs[13] = '{1'b0, 2047, 32'h0,        4'h0,    1'b1, 32'h11BB33DD};
        vecs[14] = '{1'b1, 1024, 32'h12345678, 4'hF,    1'b1, 32'h11BB33DD};
        vecs[15] = '{1'b0, 0,    32'h0,        4'h0,    1'b0, 32'h01FF03FF};
        vecs[16] = '{1'b1, 3,    32'h00000000, 4'hF,    1'b0, 32'h01FF03FF};

        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, dmem_error}, 32'd0);
        check("rst_valM", valM, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_ready", {31'b0, ready}, 32'd1);
        check("idle_done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            $display("txn %0d: wr=%0b addr=%0d data=%h be=%b", i, vecs[i].wr, vecs[i].a,
                     vecs[i].d, vecs[i].be);
            drive(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be, 1'b1,
                  vecs[i].exp_err, vecs[i].exp_val);
            drain();
        end

        // A request while busy must be dropped, not queued.
        drive(1'b0, 5, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        check("busy_ready", {31'b0, ready}, 32'd0);
        req = 1'b1; write_flag = 1'b1; addr = 11'd5; write_data = 32'h0BAD0BAD; byte_en = 4'hF;
        @(negedge CLK);
        req = 1'b0;
        drain();
        drive(1'b0, 5, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        drain();

        // Reset during WAIT discards the pending write to addr 3.
        drive(1'b1, 3, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0);
        RST_N = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 32'd1);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_err", {31'b0, dmem_error}, 32'd0);
        check("midrst_valM", valM, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        drive(1'b0, 3, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00000000);
        drain();
        drive(1'b0, 5, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        drain();
        drive(1'b0, 3, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00000000);
        drain();
        drive(1'b1, 3, 32'h0, 4'hF, 1'b1, 1'b0, 32'h00000000);
        drain();
        drive(1'b1, 3, 32'h0, 4'hF, 1'b1, 1'b0, 32'h00000000);
        drain();
        drive(1'b0, 1024, 32'h0, 4'h0, 1'b1, 1'b1, 32'h00000000);
        drain();
        @(negedge CLK);

`ifdef DMEM_STATS_EN
        check("rd_count", 32'(rd_count), 32'd3);
        check("wr_count", 32'(wr_count), 32'd2);
        check("err_count", 32'(err_count), 32'd1);
`endif
        check("err_without_done", 32'(err_leak), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory block for the CPU memory stage, replacing the fixed 11-word, single-cycle memory.
- Word-addressed storage of configurable width and depth.
- Per-byte write enables.
- req/ready/done handshake with a configurable number of wait states, so the pipeline stalls on memory access.
- Registered out-of-range error reporting; an errored access never touches the array.

Parameters:
DATA_WID, 32, data word width in bits; must be a multiple of 8.
ADDR_WID, 10, address width in bits; addr is a word index.
DEPTH, 1024, number of words implemented; must be no greater than 2**ADDR_WID.
WAIT_CYCLES, 2, wait states inserted before the array access; 0 is legal.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
req  in  1  access request; sampled only while ready=1.
write_flag  in  1  1=write, 0=read; sampled with req.
addr  in  ADDR_WID  word index.
write_data  in  DATA_WID  write data.
byte_en  in  DATA_WID/8  byte lane enables for writes; ignored on reads.
ready  out  1  block idle; a request can be accepted.
done  out  1  one-cycle completion pulse.
valM  out  DATA_WID  read data; valid when done=1 and dmem_error=0 on a read.
dmem_error  out  1  access out of range; valid only when done=1.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, done=0, dmem_error=0, valM=0, wait counter=0. The storage array is not reset; its contents are undefined until written.
- FSM states are IDLE, WAIT, ACCESS and DONE.
- IDLE, ready=1:
  - req=1 at edge T latches addr, write_flag, write_data and byte_en.
  - If addr>=DEPTH: go to DONE with error pending. done=1 and dmem_error=1 in cycle T+1. No array write. valM unchanged.
  - If WAIT_CYCLES=0: go to ACCESS.
  - Otherwise: go to WAIT with counter=WAIT_CYCLES-1.
- WAIT, ready=0:
  - counter=0: go to ACCESS.
  - Otherwise: decrement counter.
  - Input changes are ignored because the request is already latched.
- ACCESS, ready=0, one cycle:
  - Write: each byte lane i with byte_en[i]=1 is written at the edge leaving ACCESS. Other lanes keep their old value. byte_en=0 completes as a no-op.
  - Read: valM is loaded from the array at the edge leaving ACCESS.
  - Next state is DONE.
- DONE, ready=0, one cycle: done=1, dmem_error as latched. Next state is IDLE.
- Latency for an in-range access accepted at edge T: done is high in cycle T+2+WAIT_CYCLES.
- Minimum request spacing is 3+WAIT_CYCLES cycles, because ready returns one cycle after done.
- valM holds the last successful read value. Writes and errored reads do not change it.
- dmem_error=0 whenever done=0.
- req while ready=0 is ignored, not queued.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset asserted mid-transaction:
  - The FSM immediately returns to IDLE and all outputs take their reset values.
  - A write is lost if reset arrives before the ACCESS edge; otherwise it is committed.
- addr=DEPTH-1 is legal. addr=DEPTH is an error.

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs rd_count, wr_count and err_count, each 16 bits.
  - On each done pulse, exactly one of them increments: err_count if dmem_error=1, otherwise wr_count for writes and rd_count for reads.
  - Counters saturate at 16'hFFFF and reset to 0 on RST_N.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package or header:
  - DATA_WID default.
  - Encoding of the four FSM states (2-bit).
  - Counter width constant STAT_WID=16.
- Sub-module dmem_array:
  - Synchronous single-port RAM with per-byte write enable and registered read.
  - Parametrised by DATA_WID and DEPTH.
  - dmem_ctrl instantiates it and owns the FSM, wait counter and error logic.

Test Plan:
- Reset then idle: RST_N low for 2 cycles -> ready=1, done=0, dmem_error=0, valM=0.
- Write then read, WAIT_CYCLES=2: write addr=5, data=32'hDEADBEEF, byte_en=4'hF; then read addr=5 -> each done pulse 4 cycles after acceptance; the read returns valM=32'hDEADBEEF with dmem_error=0.
- Partial write: write 32'h11223344 to addr=7, then write data 32'hAABBCCDD with byte_en=4'b0101, then read addr=7 -> valM=32'h11BB33DD.
- Range error: read addr=DEPTH=1024 -> done and dmem_error both high in the cycle after acceptance; valM keeps its prior value; a following read of addr=1023 completes normally.
- Ignored request and mid-operation reset: pulse req during WAIT -> no second transaction. Write addr=3 with 32'h0 first, then write addr=3 with 32'h12345678 and assert RST_N in WAIT -> FSM in IDLE and ready=1, done=0; a subsequent read of addr=3 returns 32'h0.
- Stats with DMEM_STATS_EN: 3 reads, 2 writes, 1 error -> rd_count=3, wr_count=2, err_count=1.
